// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// Module : rr_mux_arbiter_pkg
// Brief  : Shared state encoding and default constants for rr_mux_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_mux_reg_stage.sv
// ============================================================================
// Module : mux_reg_stage
// Brief  : 2:1 data mux feeding a single output register with valid flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_reg_stage
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             load,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] mux_data;

    assign mux_data = sel ? b_data : a_data;

    // load is only raised when the register has space, so it wins over ready
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q       <= mux_data;
            q_valid <= 1'b1;
        end else if (ready) begin
            q_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module : rr_mux_arbiter
// Brief  : Two-requester round-robin arbiter with bounded bursts and a
//          registered, back-pressured output stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req_in,
    input  logic [WIDTH-1:0] a_data_in,
    output logic             a_ack_out,
    input  logic             b_req_in,
    input  logic [WIDTH-1:0] b_data_in,
    output logic             b_ack_out,
    output logic             sel_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_valid_out,
    input  logic             q_ready_in
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_t        state, state_nxt;
    logic              pri, pri_nxt;          // 0: A preferred, 1: B preferred
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic              space;
    logic              load;

    assign space     = !q_valid_out || q_ready_in;
    // acks are masked during reset so a held grant never leaks a transfer
    assign a_ack_out = (state == GRANT_A) && a_req_in && space && !rst;
    assign b_ack_out = (state == GRANT_B) && b_req_in && space && !rst;
    assign load      = a_ack_out || b_ack_out;
    assign sel_out   = (state == GRANT_B);
    assign hold_inc  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pri      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pri      <= pri_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pri_nxt   = pri;
        hold_nxt  = hold_cnt;
        if (space) begin
            case (state)
                IDLE: begin
                    if (a_req_in && b_req_in) state_nxt = pri ? GRANT_B : GRANT_A;
                    else if (a_req_in)        state_nxt = GRANT_A;
                    else if (b_req_in)        state_nxt = GRANT_B;
                end
                GRANT_A: begin
                    if (!a_req_in) begin
                        state_nxt = b_req_in ? GRANT_B : IDLE;
                        pri_nxt   = 1'b1;
                        hold_nxt  = '0;
                    end else if (hold_inc == HOLD_MAX && b_req_in) begin
                        state_nxt = GRANT_B;
                        pri_nxt   = 1'b1;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_inc;
                    end
                end
                GRANT_B: begin
                    if (!b_req_in) begin
                        state_nxt = a_req_in ? GRANT_A : IDLE;
                        pri_nxt   = 1'b0;
                        hold_nxt  = '0;
                    end else if (hold_inc == HOLD_MAX && a_req_in) begin
                        state_nxt = GRANT_A;
                        pri_nxt   = 1'b0;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    mux_reg_stage #(
        .WIDTH (WIDTH)
    ) u_mux_reg_stage (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel_out),
        .a_data  (a_data_in),
        .b_data  (b_data_in),
        .load    (load),
        .ready   (q_ready_in),
        .q       (q_out),
        .q_valid (q_valid_out)
    );

endmodule

`default_nettype wire
